// File: rtl/clock_display_pkg.sv
// Shared types, glyph codes and active-low segment patterns for the
// clock display scanner.
package clock_display_pkg;

  typedef enum logic [1:0] {PG_H = 2'd0, PG_M = 2'd1, PG_S = 2'd2} page_t;
  typedef enum logic       {AUTO = 1'b0, MANUAL = 1'b1}             mode_t;

  // Glyph codes 0..9 are the decimal digits themselves
  localparam logic [4:0] GC_A     = 5'd10;
  localparam logic [4:0] GC_P     = 5'd11;
  localparam logic [4:0] GC_E     = 5'd12;
  localparam logic [4:0] GC_DASH  = 5'd13;
  localparam logic [4:0] GC_BLANK = 5'd14;

  // {dp,g,f,e,d,c,b,a}, active low, dp off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Out-of-range BCD is shown as 'E' rather than silently corrected
  function automatic logic [4:0] bcd_code(input logic [3:0] nib);
    return (nib > 4'd9) ? GC_E : {1'b0, nib};
  endfunction

  function automatic page_t next_page(input page_t p);
    case (p)
      PG_H:    return PG_M;
      PG_M:    return PG_S;
      default: return PG_H;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph decoder: 5-bit glyph code to active-low {g..a}.
module seg7_glyph
  import clock_display_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK[6:0];
    case (code)
      5'd0:     seg_n = SEG_0[6:0];
      5'd1:     seg_n = SEG_1[6:0];
      5'd2:     seg_n = SEG_2[6:0];
      5'd3:     seg_n = SEG_3[6:0];
      5'd4:     seg_n = SEG_4[6:0];
      5'd5:     seg_n = SEG_5[6:0];
      5'd6:     seg_n = SEG_6[6:0];
      5'd7:     seg_n = SEG_7[6:0];
      5'd8:     seg_n = SEG_8[6:0];
      5'd9:     seg_n = SEG_9[6:0];
      GC_A:     seg_n = SEG_A[6:0];
      GC_P:     seg_n = SEG_P[6:0];
      GC_E:     seg_n = SEG_E[6:0];
      GC_DASH:  seg_n = SEG_DASH[6:0];
      default:  seg_n = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// 3-digit multiplexed 7-segment driver paging between hours, minutes and
// seconds, with auto-rotation and a button that pauses it.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int PAGE_SEC = 3,
  parameter int HOLD_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena_1hz,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic       page_btn,
  output logic [7:0] seg_n,
  output logic [2:0] an_n
);

  localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * 3);
  localparam int DW       = $clog2(SCAN_DIV + 1);
  localparam int PW       = $clog2(PAGE_SEC + 1);
  localparam int HW       = $clog2(HOLD_SEC + 1);
  localparam int NUM_DIG  = 3;

  // ---- digit scan ----
  logic [DW-1:0] pre;
  logic [1:0]    idx;
  logic          tc, wrap;

  assign tc   = (pre == DW'(SCAN_DIV - 1));
  assign wrap = tc && (idx == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      idx <= 2'd0;
    end else if (tc) begin
      pre <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // ---- page / mode FSM ----
  page_t         page_q, page_d;
  mode_t         mode_q, mode_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [2:0]    btn_sync;
  logic          press;

  // Two sync flops, third flop only for edge detection
  always_ff @(posedge clk) begin
    if (reset) btn_sync <= 3'b000;
    else       btn_sync <= {btn_sync[1:0], page_btn};
  end
  assign press = btn_sync[1] & ~btn_sync[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      page_q <= PG_H;
      mode_q <= AUTO;
      pcnt_q <= '0;
      hcnt_q <= '0;
    end else begin
      page_q <= page_d;
      mode_q <= mode_d;
      pcnt_q <= pcnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  // A press takes priority; a coincident 1 Hz tick is dropped
  always_comb begin
    page_d = page_q;
    mode_d = mode_q;
    pcnt_d = pcnt_q;
    hcnt_d = hcnt_q;
    if (press) begin
      page_d = next_page(page_q);
      mode_d = MANUAL;
      hcnt_d = '0;
    end else if (ena_1hz) begin
      case (mode_q)
        AUTO: begin
          if (pcnt_q == PW'(PAGE_SEC - 1)) begin
            page_d = next_page(page_q);
            pcnt_d = '0;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        default: begin
          if (hcnt_q == HW'(HOLD_SEC - 1)) begin
            mode_d = AUTO;
            pcnt_d = '0;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // ---- frame snapshot: one consistent time and page per frame ----
  logic [7:0] snap_hh, snap_mm, snap_ss;
  logic       snap_pm;
  page_t      snap_page;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_hh   <= 8'h00;
      snap_mm   <= 8'h00;
      snap_ss   <= 8'h00;
      snap_pm   <= 1'b0;
      snap_page <= PG_H;
    end else if (wrap) begin
      snap_hh   <= hh;
      snap_mm   <= mm;
      snap_ss   <= ss;
      snap_pm   <= pm;
      snap_page <= page_q;
    end
  end

  // ---- glyph selection and decode ----
  logic [NUM_DIG-1:0][4:0] dig_code;
  logic [NUM_DIG-1:0][6:0] dig_seg;
  logic                    dp_mid;

  always_comb begin
    dig_code = {NUM_DIG{GC_BLANK}};
    case (snap_page)
      PG_M: begin
        dig_code[2] = GC_DASH;
        dig_code[1] = bcd_code(snap_mm[7:4]);
        dig_code[0] = bcd_code(snap_mm[3:0]);
      end
      PG_S: begin
        dig_code[2] = GC_BLANK;
        dig_code[1] = bcd_code(snap_ss[7:4]);
        dig_code[0] = bcd_code(snap_ss[3:0]);
      end
      default: begin
        dig_code[2] = (snap_hh[7:4] == 4'd0) ? GC_BLANK : bcd_code(snap_hh[7:4]);
        dig_code[1] = bcd_code(snap_hh[3:0]);
        dig_code[0] = snap_pm ? GC_P : GC_A;
      end
    endcase
  end
  assign dp_mid = (snap_page != PG_H);

  for (genvar d = 0; d < NUM_DIG; d++) begin : g_dig
    seg7_glyph u_glyph (
      .code  (dig_code[d]),
      .seg_n (dig_seg[d])
    );
  end

  // ---- output registers ----
  logic [2:0] cur_an;
  logic [7:0] cur_seg;

  always_comb begin
    cur_an  = 3'b110;
    cur_seg = {1'b1, dig_seg[0]};
    case (idx)
      2'd1: begin
        cur_an  = 3'b101;
        cur_seg = {~dp_mid, dig_seg[1]};
      end
      2'd2: begin
        cur_an  = 3'b011;
        cur_seg = {1'b1, dig_seg[2]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n <= 8'hFF;
      an_n  <= 3'b111;
    end else begin
      seg_n <= cur_seg;
      an_n  <= cur_an;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench: table-driven hour frames plus paging, hold, tearing
// and reset sequences, checked through a per-frame scoreboard.
module tb_clock_display_scan;

  localparam int CLK_HZ = 300, SCAN_HZ = 10, PAGE_SEC = 3, HOLD_SEC = 10;

  localparam logic [7:0] T0 = 8'hC0, T1 = 8'hF9, T2 = 8'hA4, T3 = 8'hB0,
                         T4 = 8'h99, T5 = 8'h92, T7 = 8'hF8, T9 = 8'h90,
                         TA = 8'h88, TP = 8'h8C, TE = 8'h86, TD = 8'hBF,
                         TB = 8'hFF, DP = 8'h7F;

  logic       clk = 1'b0, reset = 1'b1, ena_1hz = 1'b0, pm = 1'b0, page_btn = 1'b0;
  logic [7:0] hh = 8'h00, mm = 8'h00, ss = 8'h00;
  logic [7:0] seg_n;
  logic [2:0] an_n;

  clock_display_scan #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .PAGE_SEC(PAGE_SEC), .HOLD_SEC(HOLD_SEC)
  ) dut (
    .clk(clk), .reset(reset), .ena_1hz(ena_1hz), .hh(hh), .mm(mm), .ss(ss),
    .pm(pm), .page_btn(page_btn), .seg_n(seg_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] an;
    logic [7:0] seg;
    logic [7:0] tag;
  } exp_t;

  typedef struct packed {
    logic [7:0] hh;
    logic       pm;
    logic [7:0] e2, e1, e0;
  } vec_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0, n_fail = 0;
  bit         consuming = 1'b0;
  logic [2:0] prev_an = 3'b111;

  // Scoreboard consumer: a frame starts at the first digit-0 transition
  // after expectations were queued; each digit transition pops one entry.
  always @(negedge clk) begin
    if (an_n !== prev_an) begin
      if (!consuming && sb.size() > 0 && an_n === 3'b110) consuming = 1'b1;
      if (consuming) begin
        e = sb.pop_front();
        n_cmp++;
        if (an_n !== e.an || seg_n !== e.seg) begin
          n_fail++;
          $display("FAIL frame%0d digit an=%b: got an_n=%b seg_n=%h, expected an_n=%b seg_n=%h",
                   e.tag, e.an, an_n, seg_n, e.an, e.seg);
        end
        if (sb.size() == 0) consuming = 1'b0;
      end
    end
    prev_an = an_n;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input int tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !consuming) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL frame%0d timeout: got %0d pending, expected 0", tag, sb.size());
    sb.delete();
    consuming = 1'b0;
  endtask

  task automatic check_frame(input logic [7:0] d2, d1, d0, input int tag);
    repeat (4) @(negedge clk);
    sb.push_back('{an: 3'b110, seg: d0, tag: 8'(tag)});
    sb.push_back('{an: 3'b101, seg: d1, tag: 8'(tag)});
    sb.push_back('{an: 3'b011, seg: d2, tag: 8'(tag)});
    wait_drain(tag);
  endtask

  task automatic wait_an(input logic [2:0] val);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (an_n === val) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL wait_an timeout: got %b, expected %b", an_n, val);
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ena_1hz = 1'b1;
      @(negedge clk) ena_1hz = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press();
    @(negedge clk) page_btn = 1'b1;
    repeat (5) @(negedge clk);
    page_btn = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  vec_t tbl[6];
  int   dwell;

  initial begin
    tbl[0] = '{hh: 8'h09, pm: 1'b1, e2: TB, e1: T9, e0: TP};
    tbl[1] = '{hh: 8'h12, pm: 1'b0, e2: T1, e1: T2, e0: TA};
    tbl[2] = '{hh: 8'h10, pm: 1'b1, e2: T1, e1: T0, e0: TP};
    tbl[3] = '{hh: 8'h1A, pm: 1'b0, e2: T1, e1: TE, e0: TA};
    tbl[4] = '{hh: 8'hA1, pm: 1'b1, e2: TE, e1: T1, e0: TP};
    tbl[5] = '{hh: 8'h05, pm: 1'b0, e2: TB, e1: T5, e0: TA};

    // Reset state, then first digit from the zeroed snapshot
    repeat (3) @(negedge clk);
    chk("reset an_n", {5'b0, an_n}, 8'h07);
    chk("reset seg_n", seg_n, 8'hFF);
    reset = 1'b0;
    @(negedge clk);
    chk("first an_n", {5'b0, an_n}, 8'h06);
    chk("first seg_n", seg_n, TA);

    mm = 8'h42;
    ss = 8'h37;
    foreach (tbl[i]) begin
      hh = tbl[i].hh;
      pm = tbl[i].pm;
      check_frame(tbl[i].e2, tbl[i].e1, tbl[i].e0, i);
    end

    // Digit dwell is SCAN_DIV clocks
    wait_an(3'b110);
    dwell = 1;
    while (an_n === 3'b110 && dwell < 50) begin
      @(negedge clk);
      if (an_n === 3'b110) dwell++;
    end
    chk("dwell clocks", 8'(dwell), 8'd10);
    chk("after digit0", {5'b0, an_n}, 8'h05);

    // Auto rotation every PAGE_SEC ticks
    pulse(2); check_frame(TB, T5, TA, 20);
    pulse(1); check_frame(TD, T4 & DP, T2, 21);
    pulse(3); check_frame(TB, T3 & DP, T7, 22);
    pulse(3); check_frame(TB, T5, TA, 23);

    // Press and tick in the same clock: single advance, manual mode
    pulse(2);
    @(negedge clk) page_btn = 1'b1;
    @(negedge clk);
    @(negedge clk) ena_1hz = 1'b1;
    @(negedge clk) ena_1hz = 1'b0;
    repeat (3) @(negedge clk);
    page_btn = 1'b0;
    check_frame(TD, T4 & DP, T2, 30);

    // Hold: 9 ticks keeps page, press restarts hold count
    pulse(9); check_frame(TD, T4 & DP, T2, 31);
    press();  check_frame(TB, T3 & DP, T7, 32);
    pulse(9); check_frame(TB, T3 & DP, T7, 33);
    pulse(1); pulse(2); check_frame(TB, T3 & DP, T7, 34);
    pulse(1); check_frame(TB, T5, TA, 35);

    // No tearing: inputs change while digit 1 is showing
    hh = 8'h11; pm = 1'b0;
    check_frame(T1, T1, TA, 40);
    wait_an(3'b101);
    hh = 8'h12; pm = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("tear digit1", seg_n, T1);
    wait_an(3'b011);
    chk("tear digit2", seg_n, T1);
    sb.push_back('{an: 3'b110, seg: TP, tag: 8'd41});
    sb.push_back('{an: 3'b101, seg: T2, tag: 8'd41});
    sb.push_back('{an: 3'b011, seg: T1, tag: 8'd41});
    wait_drain(41);

    // Bad BCD on the seconds page, then reset mid-frame
    ss = 8'h5C;
    press(); press();
    check_frame(TB, T5 & DP, TE, 50);
    wait_an(3'b101);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset an_n", {5'b0, an_n}, 8'h07);
    chk("midreset seg_n", seg_n, 8'hFF);
    reset = 1'b0;
    @(negedge clk);
    chk("restart an_n", {5'b0, an_n}, 8'h06);
    chk("restart seg_n", seg_n, TA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
